// File: rtl/adsr_envelope_if.sv
// Voice envelope bus: gate pulses, ADSR controls and waveform in/out between
// a waveform generator and one adsr_envelope instance.
interface adsr_envelope_if #(
  parameter int WAVE_DEPTH = 8,
  parameter int ENV_DEPTH  = 8,
  parameter int RATE_DEPTH = 8
);
  logic                  GateOpen;
  logic                  GateClose;
  logic [ENV_DEPTH-1:0]  AttackRate;
  logic [ENV_DEPTH-1:0]  DecayRate;
  logic [ENV_DEPTH-1:0]  SustainLevel;
  logic [ENV_DEPTH-1:0]  ReleaseRate;
  logic [RATE_DEPTH-1:0] TickDiv;
  logic [WAVE_DEPTH-1:0] WaveIn;
  logic [WAVE_DEPTH-1:0] WaveOut;
  logic [ENV_DEPTH-1:0]  Envelope;
  logic                  Active;

  modport master (
    output GateOpen, GateClose, AttackRate, DecayRate, SustainLevel,
           ReleaseRate, TickDiv, WaveIn,
    input  WaveOut, Envelope, Active
  );

  modport slave (
    input  GateOpen, GateClose, AttackRate, DecayRate, SustainLevel,
           ReleaseRate, TickDiv, WaveIn,
    output WaveOut, Envelope, Active
  );
endinterface

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope that scales an offset-binary waveform about its midpoint.
// Define ADSR_EXP_RELEASE_EN for a near-exponential release ((env>>4)+1 per tick).
module adsr_envelope #(
  parameter int WAVE_DEPTH = 8,
  parameter int ENV_DEPTH  = 8,
  parameter int RATE_DEPTH = 8
) (
  input logic             Clock,
  input logic             Reset,
  adsr_envelope_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  localparam logic [WAVE_DEPTH-1:0] MID     = {1'b1, {(WAVE_DEPTH-1){1'b0}}};
  localparam logic [ENV_DEPTH:0]    ENV_MAX = {1'b0, {ENV_DEPTH{1'b1}}};

  state_t                state;
  logic [ENV_DEPTH-1:0]  env;
  logic [RATE_DEPTH-1:0] cnt;
  logic [WAVE_DEPTH-1:0] wave;

  logic                  gate;
  logic                  tick;
  logic [ENV_DEPTH:0]    att_sum;
  logic [ENV_DEPTH:0]    dec_diff;
  logic [ENV_DEPTH:0]    rel_diff;
  logic [ENV_DEPTH-1:0]  rel_step;

  assign gate = bus.GateOpen | bus.GateClose;
  assign tick = (cnt == bus.TickDiv);

`ifdef ADSR_EXP_RELEASE_EN
  assign rel_step = (env >> 4) + ENV_DEPTH'(1);
`else
  assign rel_step = bus.ReleaseRate;
`endif

  // One extra bit on each step exposes overflow past ENV_MAX and underflow below 0
  assign att_sum  = {1'b0, env} + {1'b0, bus.AttackRate};
  assign dec_diff = {1'b0, env} - {1'b0, bus.DecayRate};
  assign rel_diff = {1'b0, env} - {1'b0, rel_step};

  logic                  [WAVE_DEPTH-1:0]         centred;
  logic signed           [WAVE_DEPTH+ENV_DEPTH:0] s_ext;
  logic signed           [WAVE_DEPTH+ENV_DEPTH:0] e_ext;
  logic                  [WAVE_DEPTH-1:0]         scaled;

  assign centred = bus.WaveIn - MID;
  assign s_ext   = {{(ENV_DEPTH+1){centred[WAVE_DEPTH-1]}}, centred};
  assign e_ext   = {{(WAVE_DEPTH+1){1'b0}}, env};
  // Arithmetic shift floors toward -inf; the result always fits back in WAVE_DEPTH bits
  assign scaled  = WAVE_DEPTH'((s_ext * e_ext) >>> ENV_DEPTH) + MID;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      env   <= '0;
      cnt   <= '0;
      wave  <= MID;
    end else begin
      wave <= scaled;
      if (gate) begin
        cnt <= '0;
        if (bus.GateOpen)
          state <= ATTACK;
        else if (state == ATTACK || state == DECAY || state == SUSTAIN)
          state <= RELEASE;
      end else begin
        cnt <= tick ? '0 : cnt + RATE_DEPTH'(1);
        if (tick) begin
          case (state)
            IDLE: env <= '0;
            ATTACK: begin
              if (att_sum >= ENV_MAX) begin
                env   <= '1;
                state <= DECAY;
              end else begin
                env <= att_sum[ENV_DEPTH-1:0];
              end
            end
            DECAY: begin
              if (dec_diff[ENV_DEPTH] || dec_diff[ENV_DEPTH-1:0] <= bus.SustainLevel) begin
                env   <= bus.SustainLevel;
                state <= SUSTAIN;
              end else begin
                env <= dec_diff[ENV_DEPTH-1:0];
              end
            end
            SUSTAIN: env <= bus.SustainLevel;
            RELEASE: begin
              if (rel_diff[ENV_DEPTH] || rel_diff[ENV_DEPTH-1:0] == '0) begin
                env   <= '0;
                state <= IDLE;
              end else begin
                env <= rel_diff[ENV_DEPTH-1:0];
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.Envelope = env;
  assign bus.WaveOut  = wave;
  assign bus.Active   = (state != IDLE);

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
Per-voice amplitude envelope stage directly downstream of a waveform generator. Consumes the same GateOpen/GateClose pulses that drive the generator and runs an attack/decay/sustain/release state machine. Uses the resulting envelope level to scale the generator's unsigned waveform around its midpoint. One instance per voice sits between each generator and the voice summing/rescale logic.

Parameters:
WAVE_DEPTH, 8, bit width of the waveform in and out (unsigned, offset-binary, midpoint MID = 1<<(WAVE_DEPTH-1))
ENV_DEPTH, 8, bit width of the envelope level and rate/level controls; ENV_MAX = (1<<ENV_DEPTH)-1
RATE_DEPTH, 8, width of the tick prescaler divider

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
GateOpen  input  1  single-cycle pulse: note on / retrigger
GateClose  input  1  single-cycle pulse: note off
AttackRate  input  ENV_DEPTH  envelope increment per tick in ATTACK
DecayRate  input  ENV_DEPTH  envelope decrement per tick in DECAY
SustainLevel  input  ENV_DEPTH  hold level for SUSTAIN
ReleaseRate  input  ENV_DEPTH  envelope decrement per tick in RELEASE
TickDiv  input  RATE_DEPTH  envelope updates once every TickDiv+1 clocks
WaveIn  input  WAVE_DEPTH  unsigned waveform from the generator
WaveOut  output  WAVE_DEPTH  envelope-scaled waveform, registered
Envelope  output  ENV_DEPTH  current envelope level, registered
Active  output  1  high whenever state != IDLE

Behaviour:
- Reset (async) -> state IDLE, Envelope 0, prescaler 0, WaveOut MID (0x80 at default), Active 0. Takes effect immediately, including mid-ATTACK/RELEASE.
- Prescaler counts 0..TickDiv. tick=1 in the cycle the count equals TickDiv; the count then wraps to 0. With TickDiv=0, tick=1 every cycle.
- A gate pulse clears the prescaler to 0. The first envelope update after a gate pulse occurs TickDiv+1 clocks later.
- Gate handling, applied at the edge regardless of tick, with no envelope update on that edge:
  - GateOpen in any state -> ATTACK. Envelope is not cleared (legato retrigger).
  - GateClose in ATTACK, DECAY or SUSTAIN -> RELEASE.
  - GateClose in IDLE or RELEASE is ignored.
  - GateOpen and GateClose in the same cycle: GateOpen wins.
- Envelope update on tick, computed with ENV_DEPTH+1 bits to detect over/underflow:
  - ATTACK: env+AttackRate. If >= ENV_MAX, env=ENV_MAX and go to DECAY. AttackRate=0 holds env.
  - DECAY: env-DecayRate. If <= SustainLevel (incl. underflow), env=SustainLevel and go to SUSTAIN.
  - SUSTAIN: env=SustainLevel, re-sampled every tick so live changes take effect.
  - RELEASE: env-ReleaseRate. If <= 0, env=0 and go to IDLE.
  - IDLE: env stays at 0.
- SustainLevel >= ENV_MAX: DECAY exits to SUSTAIN on the first tick.
- Scaling, registered, 1-cycle latency from WaveIn/Envelope:
  - s = signed(WaveIn - MID), WAVE_DEPTH bits.
  - p = s * {0,Envelope}, signed.
  - WaveOut = (p >>> ENV_DEPTH) + MID, with an arithmetic (flooring) shift.
  - Full-scale env gives gain ENV_MAX/2^ENV_DEPTH; no clamp is needed.
- Active is combinational from the registered state.

Optional Feature:
ADSR_EXP_RELEASE_EN
- Defined: the RELEASE step per tick is (env >> 4) + 1, giving a near-exponential tail that still reaches 0. ReleaseRate is ignored.
- Undefined: linear release using ReleaseRate, as above.

Test Plan:
1. TickDiv=0, AttackRate=0x40, DecayRate=0x10, SustainLevel=0x80, pulse GateOpen -> Envelope sequence over ticks 1..4 is 0x40, 0x80, 0xC0, 0xFF (state DECAY); then 0xEF, 0xDF, 0xCF, 0xBF, 0xAF, 0x9F, 0x8F, 0x80 (state SUSTAIN); Active=1 throughout.
2. In SUSTAIN at 0x80, ReleaseRate=0x20, pulse GateClose -> 0x60, 0x40, 0x20, 0x00 on successive ticks; IDLE and Active=0 on the edge reaching 0x00. With ADSR_EXP_RELEASE_EN, the first step gives 0x80 -> 0x77.
3. TickDiv=3, AttackRate=0x10 -> Envelope changes only every 4th clock after GateOpen: 0x10 at clock 4, 0x20 at clock 8.
4. In RELEASE at env 0x30, GateOpen and GateClose asserted the same cycle -> state ATTACK; env continues from 0x30 (0x30+AttackRate on the next tick).
5. Hold env 0xFF: WaveIn=0xFF -> WaveOut=0xFE one clock later; WaveIn=0x00 -> 0x00. Hold env 0x80: WaveIn=0x00 -> WaveOut=0x40. In IDLE (env 0), any WaveIn -> 0x80.
6. Assert Reset mid-ATTACK (env 0x80) between clock edges -> Envelope=0, WaveOut=0x80, Active=0 immediately. After release, GateClose is ignored and GateOpen restarts ATTACK from 0.
